rf_writeback_scheduler: RTL

- Shares the single register-file write port between two writeback requesters: req0 (ALU/branch-link path) and req1 (load/memory path).
- Keeps a per-register pending-write scoreboard that stalls issue on RAW and WAW hazards.
- Sits between the execute/memory stages and the register file, driving its write_enable/rd/rd_din inputs from registered outputs.
- The register file reads asynchronously and writes on posedge clk.

---
 rtl/rf_writeback_scheduler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/rf_writeback_scheduler.sv
// rf_writeback_scheduler
// Shares the single register-file write port between two writeback
// requesters (req0: ALU/branch-link, req1: load/memory). It also keeps a
// per-register pending-write scoreboard that stalls issue on RAW/WAW hazards.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   issue_valid/rs1/rs2/rd  instruction presented for issue
//   issue_stall          issue must hold this cycle (combinational)
//   reqN_valid/rd/data   writeback request N
//   reqN_ready           request N accepted this cycle (combinational grant)
//   rf_we/rf_rd/rf_din   registered register-file write port
//   pending              scoreboard bitmap, bit n = write to xn outstanding
module rf_writeback_scheduler #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned RESET_PRIO = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rs1,
    input  logic [4:0]      issue_rs2,
    input  logic [4:0]      issue_rd,
    output logic            issue_stall,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [4:0]      req0_rd,
    input  logic [XLEN-1:0] req0_data,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [4:0]      req1_rd,
    input  logic [XLEN-1:0] req1_data,
    output logic            rf_we,
    output logic [4:0]      rf_rd,
    output logic [XLEN-1:0] rf_din,
    output logic [31:0]     pending
);

    localparam int unsigned NREG = 32;

    // last_grant = index granted at the most recent accept; the other
    // requester wins the next contention. Reset value lets RESET_PRIO win.
    localparam logic LAST_RST = (RESET_PRIO == 0) ? 1'b1 : 1'b0;

    logic            last_grant;
    logic            grant0;
    logic            grant1;
    logic            wr_en;
    logic [4:0]      wr_rd;
    logic [XLEN-1:0] wr_data;
    logic            issue_fire;
    logic [NREG-1:0] pending_next;

    // Round-robin arbitration between the two writeback requesters
    always_comb begin
        grant0 = req0_valid & (~req1_valid | last_grant);
        grant1 = req1_valid & (~req0_valid | ~last_grant);
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Select the accepted write; rd=0 is consumed without writing
    always_comb begin
        wr_en   = 1'b0;
        wr_rd   = req0_rd;
        wr_data = req0_data;
        if (grant0) begin
            wr_en   = (req0_rd != 5'd0);
            wr_rd   = req0_rd;
            wr_data = req0_data;
        end else if (grant1) begin
            wr_en   = (req1_rd != 5'd0);
            wr_rd   = req1_rd;
            wr_data = req1_data;
        end
    end

    // Hazard stall from registered pending only; x0 never contributes
    always_comb begin
        issue_stall = issue_valid &
                      (((issue_rs1 != 5'd0) & pending[issue_rs1]) |
                       ((issue_rs2 != 5'd0) & pending[issue_rs2]) |
                       ((issue_rd  != 5'd0) & pending[issue_rd]));
    end

    assign issue_fire = issue_valid & ~issue_stall & (issue_rd != 5'd0);

    // Scoreboard update: clear on commit first so a same-edge set wins
    always_comb begin
        pending_next = pending;
        if (rf_we) begin
            pending_next[rf_rd] = 1'b0;
        end
        if (issue_fire) begin
            pending_next[issue_rd] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    // Pointer, write-port register and scoreboard flops
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= LAST_RST;
            rf_we      <= 1'b0;
            rf_rd      <= 5'd0;
            rf_din     <= XLEN'(0);
            pending    <= 32'd0;
        end else begin
            if (grant0) begin
                last_grant <= 1'b0;
            end else if (grant1) begin
                last_grant <= 1'b1;
            end
            rf_we <= wr_en;
            if (wr_en) begin
                rf_rd  <= wr_rd;
                rf_din <= wr_data;
            end
            pending <= pending_next;
        end
    end

endmodule
